// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: op encoding shared by the register-file ALU pipeline and its ALU core.
package reg_alu_pkg;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRA, OP_PASS} alu_op_e;
endpackage

// File: rtl/reg_alu_pipe_alu_core.sv
// alu_core: combinational ALU with signed overflow/underflow detection and optional saturation.
module alu_core
    import reg_alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] y,
    output logic             ovf,
    output logic             udf
);
    localparam int SH = $clog2(WIDTH);
    logic [WIDTH:0] ext;
    logic           arith;
    always_comb begin
        // One guard bit is enough to tell a wrapped result from the true signed sum/difference.
        ext   = op == OP_SUB ? {a[WIDTH-1], a} - {b[WIDTH-1], b} : {a[WIDTH-1], a} + {b[WIDTH-1], b};
        arith = op == OP_ADD || op == OP_SUB;
        ovf   = arith && !ext[WIDTH] && ext[WIDTH-1];
        udf   = arith && ext[WIDTH] && !ext[WIDTH-1];
        case (op)
            OP_ADD, OP_SUB: y = SATURATE && ovf ? {1'b0, {(WIDTH-1){1'b1}}} :
                                SATURATE && udf ? {1'b1, {(WIDTH-1){1'b0}}} : ext[WIDTH-1:0];
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << b[SH-1:0];
            OP_SRA:  y = $signed(a) >>> b[SH-1:0];
            default: y = a;
        endcase
    end
endmodule

// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: register file + ALU with one registered result stage (valid/ready),
// delayed write-back with operand bypass, and sticky overflow/underflow flags.
module reg_alu_pipe
    import reg_alu_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 8,
    parameter  bit SATURATE = 1'b0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_na,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_src_alu,
    input  logic             in_wr_en,
    input  logic [AW-1:0]    in_wr_sel,
    input  logic [AW-1:0]    in_rd_sel_1,
    input  logic [AW-1:0]    in_rd_sel_2,
    input  logic [WIDTH-1:0] in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             res_udf,
    output logic             sticky_ovf,
    output logic             sticky_udf,
    input  logic             flag_clr
);
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] wb_data_q, res_data_q, res_data_d, op_a, op_b, alu_y;
    logic [AW-1:0]    wb_sel_q;
    logic             wb_pending_q, res_valid_q, res_ovf_q, res_udf_q, sticky_ovf_q, sticky_udf_q;
    logic             wb_pending_d, res_valid_d, res_ovf_d, res_udf_d, sticky_ovf_d, sticky_udf_d;
    logic             alu_ovf, alu_udf, accept;

    alu_core #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_alu (
        .a(op_a), .b(op_b), .op(alu_op_e'(in_op)), .y(alu_y), .ovf(alu_ovf), .udf(alu_udf)
    );

    always_comb begin
        // The pending write-back is not yet in the array, so forward it to keep reads newest-first.
        op_a         = wb_pending_q && wb_sel_q == in_rd_sel_1 ? wb_data_q : regs_q[in_rd_sel_1];
        op_b         = wb_pending_q && wb_sel_q == in_rd_sel_2 ? wb_data_q : regs_q[in_rd_sel_2];
        in_ready     = !res_valid_q || res_ready;
        accept       = in_valid && in_ready;
        res_data_d   = in_src_alu ? alu_y : in_data;
        res_ovf_d    = in_src_alu && alu_ovf;
        res_udf_d    = in_src_alu && alu_udf;
        res_valid_d  = accept || (res_valid_q && !res_ready);
        wb_pending_d = accept && in_wr_en;
        sticky_ovf_d = (sticky_ovf_q && !flag_clr) || (accept && res_ovf_d);
        sticky_udf_d = (sticky_udf_q && !flag_clr) || (accept && res_udf_d);
    end

    always_ff @(posedge clk or negedge rst_na) begin
        if (!rst_na) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            wb_pending_q <= 1'b0;
            wb_sel_q     <= '0;
            wb_data_q    <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_ovf_q    <= 1'b0;
            res_udf_q    <= 1'b0;
            sticky_ovf_q <= 1'b0;
            sticky_udf_q <= 1'b0;
        end else begin
            if (wb_pending_q) regs_q[wb_sel_q] <= wb_data_q;
            if (accept) begin
                res_data_q <= res_data_d;
                res_ovf_q  <= res_ovf_d;
                res_udf_q  <= res_udf_d;
            end
            if (wb_pending_d) begin
                wb_sel_q  <= in_wr_sel;
                wb_data_q <= res_data_d;
            end
            wb_pending_q <= wb_pending_d;
            res_valid_q  <= res_valid_d;
            sticky_ovf_q <= sticky_ovf_d;
            sticky_udf_q <= sticky_udf_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_ovf    = res_ovf_q;
    assign res_udf    = res_udf_q;
    assign sticky_ovf = sticky_ovf_q;
    assign sticky_udf = sticky_udf_q;
endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb_reg_alu_pipe: wrapping and saturating instances driven in lockstep and checked
// against an architectural model (registers update instantly, results by integer arithmetic).
module tb_reg_alu_pipe;
    import reg_alu_pkg::*;
    localparam int W = 16;
    logic         clk = 1'b0, rst_na = 1'b0;
    logic         in_valid = 1'b0, in_src_alu = 1'b0, in_wr_en = 1'b0, res_ready = 1'b1, flag_clr = 1'b0;
    logic [2:0]   in_op = 3'd0, in_wr_sel = 3'd0, in_rd_sel_1 = 3'd0, in_rd_sel_2 = 3'd0;
    logic [W-1:0] in_data = '0;
    logic         o_rdy [2], o_vld [2], o_ovf [2], o_udf [2], o_sov [2], o_sud [2];
    logic [W-1:0] o_data [2];
    logic [W-1:0] m_regs [2][8];
    logic [W-1:0] m_data [2];
    logic         m_ovf [2], m_udf [2], m_sov [2], m_sud [2];
    logic         m_valid = 1'b0;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        reg_alu_pipe #(.WIDTH(W), .DEPTH(8), .SATURATE(g == 1)) dut (
            .clk(clk), .rst_na(rst_na), .in_valid(in_valid), .in_ready(o_rdy[g]), .in_op(in_op),
            .in_src_alu(in_src_alu), .in_wr_en(in_wr_en), .in_wr_sel(in_wr_sel),
            .in_rd_sel_1(in_rd_sel_1), .in_rd_sel_2(in_rd_sel_2), .in_data(in_data),
            .res_valid(o_vld[g]), .res_ready(res_ready), .res_data(o_data[g]), .res_ovf(o_ovf[g]),
            .res_udf(o_udf[g]), .sticky_ovf(o_sov[g]), .sticky_udf(o_sud[g]), .flag_clr(flag_clr)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void alu_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      input bit sat, output logic [W-1:0] y, output logic o, output logic u);
        int sa, sb, t;
        sa = $signed(a);
        sb = $signed(b);
        o = 1'b0;
        u = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                t = op == OP_ADD ? sa + sb : sa - sb;
                o = t > 32767;
                u = t < -32768;
                y = sat && o ? 16'h7FFF : sat && u ? 16'h8000 : t[W-1:0];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << (b % 16);
            OP_SRA:  begin t = sa >>> (b % 16); y = t[W-1:0]; end
            default: y = a;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_vld%0d", tag, k), o_vld[k], m_valid);
            if (m_valid) begin
                chk($sformatf("%s_data%0d", tag, k), o_data[k], m_data[k]);
                chk($sformatf("%s_ovf%0d", tag, k), o_ovf[k], m_ovf[k]);
                chk($sformatf("%s_udf%0d", tag, k), o_udf[k], m_udf[k]);
            end
            chk($sformatf("%s_sov%0d", tag, k), o_sov[k], m_sov[k]);
            chk($sformatf("%s_sud%0d", tag, k), o_sud[k], m_sud[k]);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [2:0] op, input logic alu, input logic we,
                        input logic [2:0] ws, input logic [2:0] r1, input logic [2:0] r2,
                        input logic [W-1:0] d, input logic rr = 1'b1, input logic fc = 1'b0);
        logic acc, o, u;
        logic [W-1:0] y;
        in_valid = v; in_op = op; in_src_alu = alu; in_wr_en = we; in_wr_sel = ws;
        in_rd_sel_1 = r1; in_rd_sel_2 = r2; in_data = d; res_ready = rr; flag_clr = fc;
        #1;
        acc = v && (!m_valid || rr);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_rdy%0d", tag, k), o_rdy[k], !m_valid || rr);
            o = 1'b0;
            u = 1'b0;
            if (acc) begin
                if (alu) alu_model(op, m_regs[k][r1], m_regs[k][r2], k == 1, y, o, u);
                else y = d;
                m_data[k] = y; m_ovf[k] = o; m_udf[k] = u;
                if (we) m_regs[k][ws] = y;
            end
            m_sov[k] = (m_sov[k] && !fc) || o;
            m_sud[k] = (m_sud[k] && !fc) || u;
        end
        m_valid = acc || (m_valid && !rr);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset;
        in_valid = 1'b0; flag_clr = 1'b0; res_ready = 1'b1;
        rst_na = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_vld%0d", k), o_vld[k], 1'b0);
            chk($sformatf("rst_data%0d", k), o_data[k], 16'h0);
            chk($sformatf("rst_flags%0d", k), {o_ovf[k], o_udf[k], o_sov[k], o_sud[k]}, 4'h0);
            chk($sformatf("rst_rdy%0d", k), o_rdy[k], 1'b1);
            for (int r = 0; r < 8; r++) m_regs[k][r] = '0;
            m_data[k] = '0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0; m_sov[k] = 1'b0; m_sud[k] = 1'b0;
        end
        m_valid = 1'b0;
        @(negedge clk);
        rst_na = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++) step("rst_read", 1, OP_PASS, 1, 0, 0, 3'(r), 0, 0);
    endtask

    initial begin
        logic [W-1:0] held;
        #1;
        do_reset();
        // overflow on ADD
        step("ld_r1", 1, OP_ADD, 0, 1, 1, 0, 0, 16'h7FFF);
        step("ld_r2", 1, OP_ADD, 0, 1, 2, 0, 0, 16'h0001);
        step("add_ovf", 1, OP_ADD, 1, 0, 0, 1, 2, 0);
        chk("add_wrap_data", o_data[0], 16'h8000);
        chk("add_sat_data", o_data[1], 16'h7FFF);
        chk("add_ovf_flag", {o_ovf[0], o_ovf[1], o_sov[0]}, 3'b111);
        // underflow on SUB
        step("ld_r5", 1, OP_ADD, 0, 1, 5, 0, 0, 16'h8000);
        step("ld_r6", 1, OP_ADD, 0, 1, 6, 0, 0, 16'h0001);
        step("sub_udf", 1, OP_SUB, 1, 0, 0, 5, 6, 0);
        chk("sub_wrap_data", o_data[0], 16'h7FFF);
        chk("sub_sat_data", o_data[1], 16'h8000);
        chk("sub_udf_flag", {o_udf[0], o_udf[1], o_sud[1]}, 3'b111);
        // back-to-back dependence through bypass
        step("ld_r3", 1, OP_ADD, 0, 1, 3, 0, 0, 16'd5);
        step("dep_add", 1, OP_ADD, 1, 1, 4, 3, 3, 0);
        chk("dep_add_data", o_data[0], 16'd10);
        // backpressure: held result stays put while its write-back still lands
        step("bp_op", 1, OP_ADD, 1, 1, 7, 3, 4, 0);
        held = o_data[0];
        for (int i = 0; i < 3; i++) step("bp_stall", 1, OP_XOR, 1, 1, 0, 1, 2, 0, 0);
        chk("bp_held", o_data[0], held);
        step("bp_read_r7", 1, OP_PASS, 1, 0, 0, 7, 0, 0);
        chk("bp_r7", o_data[0], 16'd15);
        for (int i = 0; i < 3; i++) step("bp_resume", 1, OP_OR, 1, 0, 0, 3'(i), 4, 0);
        // sticky flags: clear coinciding with a new overflow loses to the set
        step("clr_only", 0, OP_ADD, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("clr_only_sov", o_sov[0], 1'b0);
        step("clr_and_set", 1, OP_ADD, 1, 0, 0, 1, 2, 0, 1, 1);
        chk("clr_and_set_sov", o_sov[0], 1'b1);
        step("clr_again", 0, OP_ADD, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("clr_again_sov", o_sov[0], 1'b0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom), 1'($urandom),
                 3'($urandom), 3'($urandom), 3'($urandom),
                 $urandom_range(0, 3) == 0 ? 16'(($urandom_range(0, 1) << 15) - $urandom_range(0, 1)) : 16'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
        // reset in the middle of a stalled, write-pending stream
        step("pre_rst", 1, OP_ADD, 0, 1, 6, 0, 0, 16'h1234, 0);
        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
